// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code run sequencer.
package gray_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Run modes, sampled on start
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    // Widest counter the helper converts; callers zero-extend and truncate.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_prescaler.sv
// Step-rate divider: one tick every (i_div+1) enabled clocks.
// The count is frozen while i_enable is low, so pausing keeps the phase.
module gray_seq_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_enable,
    input  logic [PRESCALE_W-1:0] i_div,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == i_div);

    // Count enabled clocks, return to 0 on tick or clear
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_tick ? '0 : r_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/gray_count_sequencer.sv
// Run controller for an N-bit Gray-code counter: start/stop/pause,
// prescaled step rate, terminal count, one-shot or continuous mode.
// Optional macro GRAY_SEQ_DOWN_EN adds i_dir for down-counting runs.
module gray_count_sequencer
    import gray_seq_pkg::*;
#(
    parameter int N          = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_pause,
`ifdef GRAY_SEQ_DOWN_EN
    input  logic                  i_dir,
`endif
    input  logic                  i_mode,
    input  logic [N-1:0]          i_term,
    input  logic [PRESCALE_W-1:0] i_div,
    output logic [N-1:0]          o_gray_count,
    output logic                  o_busy,
    output logic                  o_step,
    output logic                  o_wrap,
    output logic                  o_done
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N-1:0]          r_bin;
    logic [N-1:0]          w_bin_nxt;
    logic [N-1:0]          r_gray;
    logic [N-1:0]          r_term;
    logic                  r_mode;
    logic [PRESCALE_W-1:0] r_div;
    logic                  r_step;
    logic                  r_wrap;
    logic                  r_done;
    logic                  w_step;
    logic                  w_wrap;
    logic                  w_done;
    logic                  w_run_active;
    logic                  w_tick;
    logic                  w_dn;
    logic [N-1:0]          w_start_bin;
    logic [N-1:0]          w_end_bin;
    logic [N-1:0]          w_reload_bin;
    logic [N-1:0]          w_adv_bin;

`ifdef GRAY_SEQ_DOWN_EN
    logic r_dir;

    // Direction is part of the run configuration
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dir <= 1'b0;
        end else if (i_start && !i_stop) begin
            r_dir <= i_dir;
        end
    end

    assign w_dn        = r_dir;
    assign w_start_bin = i_dir ? i_term : '0;
`else
    assign w_dn        = 1'b0;
    assign w_start_bin = '0;
`endif

    // Down runs end at 0 and reload the terminal; up runs the reverse.
    assign w_end_bin    = w_dn ? '0 : r_term;
    assign w_reload_bin = w_dn ? r_term : '0;
    assign w_adv_bin    = w_dn ? r_bin - N'(1) : r_bin + N'(1);

    // Prescaler only advances in an undisturbed RUN cycle
    assign w_run_active = (r_state == RUN) && !i_stop && !i_start && !i_pause;

    gray_seq_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_stop || i_start),
        .i_enable (w_run_active),
        .i_div    (r_div),
        .o_tick   (w_tick)
    );

    // Next state, next count and pulse decode; stop beats start beats pause
    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_step      = 1'b0;
        w_wrap      = 1'b0;
        w_done      = 1'b0;
        if (i_stop) begin
            w_state_nxt = IDLE;
            w_bin_nxt   = '0;
        end else if (i_start) begin
            w_state_nxt = RUN;
            w_bin_nxt   = w_start_bin;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_pause) begin
                        w_state_nxt = HOLD;
                    end else if (w_tick) begin
                        w_step = 1'b1;
                        if (r_bin != w_end_bin) begin
                            w_bin_nxt = w_adv_bin;
                        end else if (r_mode == MODE_ONESHOT) begin
                            w_state_nxt = DONE;
                            w_done      = 1'b1;
                        end else begin
                            w_bin_nxt = w_reload_bin;
                            w_wrap    = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!i_pause) begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // State, count, Gray register and pulses update on the same edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_gray  <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_gray  <= N'(bin2gray(GRAY_MAX_W'(w_bin_nxt)));
            r_step  <= w_step;
            r_wrap  <= w_wrap;
            r_done  <= w_done;
        end
    end

    // Latch run configuration on start; mid-run changes are ignored
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode <= MODE_ONESHOT;
            r_term <= '0;
            r_div  <= '0;
        end else if (i_start && !i_stop) begin
            r_mode <= i_mode;
            r_term <= i_term;
            r_div  <= i_div;
        end
    end

    assign o_gray_count = r_gray;
    assign o_busy       = (r_state == RUN) || (r_state == HOLD);
    assign o_step       = r_step;
    assign o_wrap       = r_wrap;
    assign o_done       = r_done;

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Self-checking bench for gray_count_sequencer: directed scenarios plus a
// randomized run, all compared each cycle to a countdown-based reference.
module tb_gray_count_sequencer;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int M  = 1 << N;

    logic          clk = 1'b0;
    logic          rst, start, stop, pause, mode;
    logic [N-1:0]  term;
    logic [PW-1:0] div;
`ifdef GRAY_SEQ_DOWN_EN
    logic          dir;
`endif
    logic [N-1:0]  gray;
    logic          busy, step, wrap, done;

    int checks = 0;
    int errors = 0;

    // Reference: state as text-like ints, clocks-to-next-step countdown
    int m_st;   // 0 idle, 1 run, 2 hold, 3 done
    int m_bin, m_term, m_div, m_wait, m_mode, m_dir;
    int m_step, m_wrap, m_done;

    always #5 clk = ~clk;

    gray_count_sequencer #(.N(N), .PRESCALE_W(PW)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_pause      (pause),
`ifdef GRAY_SEQ_DOWN_EN
        .i_dir        (dir),
`endif
        .i_mode       (mode),
        .i_term       (term),
        .i_div        (div),
        .o_gray_count (gray),
        .o_busy       (busy),
        .o_step       (step),
        .o_wrap       (wrap),
        .o_done       (done)
    );

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & (M - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock using the current inputs
    task automatic model_update();
        int endv;
        m_step = 0; m_wrap = 0; m_done = 0;
        if (rst) begin
            m_st = 0; m_bin = 0; m_term = 0; m_div = 0; m_mode = 0; m_dir = 0; m_wait = 0;
        end else if (stop) begin
            m_st = 0; m_bin = 0;
        end else if (start) begin
            m_mode = mode; m_term = term; m_div = div; m_wait = div + 1;
`ifdef GRAY_SEQ_DOWN_EN
            m_dir = dir;
`else
            m_dir = 0;
`endif
            m_bin = m_dir ? m_term : 0;
            m_st  = 1;
        end else if (m_st == 3) begin
            m_st = 0;
        end else if (m_st == 2) begin
            if (!pause) m_st = 1;
        end else if (m_st == 1) begin
            if (pause) begin
                m_st = 2;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_wait = m_div + 1;
                    m_step = 1;
                    endv = m_dir ? 0 : m_term;
                    if (m_bin != endv)    m_bin = m_dir ? (m_bin + M - 1) % M : (m_bin + 1) % M;
                    else if (m_mode == 0) begin m_st = 3; m_done = 1; end
                    else begin m_bin = m_dir ? m_term : 0; m_wrap = 1; end
                end
            end
        end
    endtask

    // One clock: update reference, then sample DUT after the edge
    task automatic cyc();
        model_update();
        @(posedge clk);
        #1;
        chk("gray", gray, gray_of(m_bin));
        chk("busy", busy, (m_st == 1 || m_st == 2));
        chk("step", step, m_step);
        chk("wrap", wrap, m_wrap);
        chk("done", done, m_done);
    endtask

    task automatic go(input int md, input int tm, input int dv);
        mode = md[0]; term = tm[N-1:0]; div = dv[PW-1:0]; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        logic [N-1:0] q[$];
        logic [N-1:0] exp2 [6];
        logic [N-1:0] prev;
        int nstep, nwrap, ndone;

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 1'b0; term = '0; div = '0;
`ifdef GRAY_SEQ_DOWN_EN
        dir = 1'b0;
`endif
        m_st = 0; m_bin = 0; m_term = 0; m_div = 0; m_wait = 0; m_mode = 0; m_dir = 0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_gray", gray, 0);
        chk("reset_busy", busy, 0);

        // Reset mid-run at count 5
        go(1, 15, 0);
        for (int i = 0; i < 40 && m_bin != 5; i++) cyc();
        chk("t1_reach5", gray, gray_of(5));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t1_rst_gray", gray, 0);
        chk("t1_rst_busy", busy, 0);

        // One-shot term=5, div=2
        exp2 = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd7};
        go(0, 5, 2);
        chk("t2_start_gray", gray, 0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (step) q.push_back(gray);
            if (done) ndone++;
        end
        chk("t2_nsteps", q.size(), 6);
        for (int i = 0; i < 6 && i < q.size(); i++) chk("t2_seq", q[i], exp2[i]);
        chk("t2_ndone", ndone, 1);
        chk("t2_hold", gray, 4'b0111);

        // Continuous full range with single-bit transitions
        go(1, 15, 0);
        nstep = 0; nwrap = 0; prev = gray;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (step) begin
                nstep++;
                chk("t3_onebit", $countones(gray ^ prev), 1);
            end
            if (wrap) nwrap++;
            prev = gray;
        end
        chk("t3_nsteps", nstep, 16);
        chk("t3_nwrap", nwrap, 1);
        chk("t3_back0", gray, 0);

        // Pause for 7 clocks at div=1
        go(1, 15, 1);
        for (int i = 0; i < 3; i++) cyc();
        pause = 1'b1; nstep = 0; prev = gray;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (step) nstep++;
        end
        chk("t4_pause_steps", nstep, 0);
        chk("t4_pause_gray", gray, prev);
        pause = 1'b0;
        for (int i = 0; i < 8; i++) cyc();

        // Start and stop together while running, then restart mid-run
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_gray", gray, 0);
        go(1, 15, 0);
        for (int i = 0; i < 5; i++) cyc();
        go(1, 15, 0);
        chk("t5_restart_gray", gray, 0);
        chk("t5_restart_busy", busy, 1);

        // term=0: continuous wraps every (div+1) clocks
        go(1, 0, 2);
        nwrap = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (wrap) nwrap++;
        end
        chk("t7_wraps", nwrap, 3);
        chk("t7_gray", gray, 0);

        // div=255: first step exactly 256 clocks after start
        go(1, 15, 255);
        nstep = 0;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (step) nstep++;
        end
        chk("t8_nostep", nstep, 0);
        cyc();
        chk("t8_step", step, 1);
        stop = 1'b1; cyc(); stop = 1'b0;

`ifdef GRAY_SEQ_DOWN_EN
        // Down count from term=3, one-shot
        dir = 1'b1;
        go(0, 3, 0);
        chk("t6_start_gray", gray, gray_of(3));
        dir = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
`endif

        // Randomized run
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            mode  = $urandom_range(0, 1);
            term  = N'($urandom_range(0, M - 1));
            div   = PW'($urandom_range(0, 3));
`ifdef GRAY_SEQ_DOWN_EN
            dir   = $urandom_range(0, 1);
`endif
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
